// File: rtl/mem_access_stage.sv
// Memory stage after the execute ALU: single-outstanding req/ack data bus, load alignment
// and extension, registered writeback with misalignment and bus-timeout aborts.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ex_valid,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_reg_write_data,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_write,
    input  logic [3:0]  i_data_write_byte,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned,
    output logic        o_bus_timeout
);

    localparam logic [7:0] W_LIMIT = 8'(MAX_WAIT - 1);

    typedef enum logic {StIdle, StAccess} state_t;

    state_t      r_state;
    logic [7:0]  r_wait;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_is_store;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_op_wen;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_load_ok;

    assign w_is_load  = (i_opcode == 7'b0000011);
    assign w_is_store = (i_opcode == 7'b0100011);
    assign w_is_mem   = w_is_load | w_is_store;

    assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_data_addr[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_data_addr[1:0] != 2'b00));

    assign w_op_wen = (i_opcode == 7'b0110011) || (i_opcode == 7'b0010011) ||
                      (i_opcode == 7'b1101111) || (i_opcode == 7'b1100111) ||
                      (i_opcode == 7'b0010111) || (i_opcode == 7'b0110111);

    // An ack on the last allowed cycle wins over the timeout.
    assign w_timeout = (r_state == StAccess) && !i_mem_ack && (r_wait == W_LIMIT);

    assign o_stall = ((r_state == StIdle) && i_ex_valid && w_is_mem && !w_misaligned) ||
                     ((r_state == StAccess) && !i_mem_ack && !w_timeout);

    assign w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        w_load_data = 32'h0;
        w_load_ok   = 1'b1;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = i_mem_rdata;
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_wait        <= 8'h0;
            r_rd          <= 5'h0;
            r_funct3      <= 3'h0;
            r_off         <= 2'h0;
            r_is_store    <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= 32'h0;
            o_mem_wdata   <= 32'h0;
            o_mem_wstrb   <= 4'h0;
            o_wb_valid    <= 1'b0;
            o_wb_we       <= 1'b0;
            o_wb_rd       <= 5'h0;
            o_wb_data     <= 32'h0;
            o_misaligned  <= 1'b0;
            o_bus_timeout <= 1'b0;
        end else begin
            o_wb_valid    <= 1'b0;
            o_wb_we       <= 1'b0;
            o_misaligned  <= 1'b0;
            o_bus_timeout <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_ex_valid && w_is_mem && w_misaligned) begin
                        o_wb_valid   <= 1'b1;
                        o_wb_rd      <= i_rd;
                        o_wb_data    <= 32'h0;
                        o_misaligned <= 1'b1;
                    end else if (i_ex_valid && w_is_mem) begin
                        r_state     <= StAccess;
                        r_wait      <= 8'h0;
                        r_rd        <= i_rd;
                        r_funct3    <= i_funct3;
                        r_off       <= i_data_addr[1:0];
                        r_is_store  <= w_is_store;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= w_is_store;
                        o_mem_addr  <= {i_data_addr[31:2], 2'b00};
                        o_mem_wdata <= i_data_write;
                        o_mem_wstrb <= w_is_store ? i_data_write_byte : 4'h0;
                    end else if (i_ex_valid) begin
                        o_wb_valid <= 1'b1;
                        o_wb_we    <= w_op_wen && (i_rd != 5'h0);
                        o_wb_rd    <= i_rd;
                        o_wb_data  <= i_reg_write_data;
                    end
                end
                StAccess: begin
                    if (i_mem_ack || w_timeout) begin
                        r_state     <= StIdle;
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_wstrb <= 4'h0;
                        o_wb_valid  <= 1'b1;
                        o_wb_rd     <= r_rd;
                        if (i_mem_ack && !r_is_store) begin
                            o_wb_we   <= w_load_ok && (r_rd != 5'h0);
                            o_wb_data <= w_load_data;
                        end else begin
                            o_wb_data     <= 32'h0;
                            o_bus_timeout <= !i_mem_ack;
                        end
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU passthrough, loads/stores, misalignment,
// bus timeout (MAX_WAIT=4) and reset during an access.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] reg_write_data, data_addr, data_write;
    logic [3:0]  data_write_byte;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, wb_we, misaligned, bus_timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the last mem_op call.
    int          g_stall_cnt, g_req_cnt, g_hold_err;
    logic        g_we;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wstrb;

    always #5 clk = ~clk;

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_ex_valid       (ex_valid),
        .i_opcode         (opcode),
        .i_funct3         (funct3),
        .i_rd             (rd),
        .i_reg_write_data (reg_write_data),
        .i_data_addr      (data_addr),
        .i_data_write     (data_write),
        .i_data_write_byte(data_write_byte),
        .o_stall          (stall),
        .o_mem_req        (mem_req),
        .o_mem_we         (mem_we),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .o_mem_wstrb      (mem_wstrb),
        .i_mem_ack        (mem_ack),
        .i_mem_rdata      (mem_rdata),
        .o_wb_valid       (wb_valid),
        .o_wb_we          (wb_we),
        .o_wb_rd          (wb_rd),
        .o_wb_data        (wb_data),
        .o_misaligned     (misaligned),
        .o_bus_timeout    (bus_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic v, input logic we, input logic [4:0] r,
                            input logic [31:0] d, input logic mis, input logic tmo);
        check_eq({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
        check_eq({tag, ".wb_we"}, 32'(wb_we), 32'(we));
        check_eq({tag, ".wb_rd"}, 32'(wb_rd), 32'(r));
        check_eq({tag, ".wb_data"}, wb_data, d);
        check_eq({tag, ".misaligned"}, 32'(misaligned), 32'(mis));
        check_eq({tag, ".bus_timeout"}, 32'(bus_timeout), 32'(tmo));
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    // Presents one non-memory op for one cycle; leaves writeback visible on return.
    task automatic alu_op(input logic [6:0] op, input logic [4:0] r, input logic [31:0] d);
        @(negedge clk);
        ex_valid = 1'b1; opcode = op; funct3 = 3'b000; rd = r; reg_write_data = d;
        #1;
        check_eq("alu.stall", 32'(stall), 32'h0);
        @(negedge clk);
        idle_inputs();
    endtask

    // Presents a load/store held while stalled; ack in ACCESS cycle ack_cyc (0 = never).
    task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wb,
                          input int ack_cyc, input logic [31:0] rdata);
        bit done;
        @(negedge clk);
        ex_valid = 1'b1; opcode = op; funct3 = f3; rd = r;
        data_addr = addr; data_write = wd; data_write_byte = wb; mem_ack = 1'b0;
        #1;
        g_stall_cnt = stall ? 1 : 0;
        g_req_cnt   = 0;
        g_hold_err  = 0;
        done        = (stall == 1'b0);
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (mem_req) g_req_cnt++;
            if (k == 1) begin
                g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata; g_wstrb = mem_wstrb;
            end else if (mem_req && (mem_we !== g_we || mem_addr !== g_addr ||
                                     mem_wdata !== g_wdata || mem_wstrb !== g_wstrb)) begin
                g_hold_err++;
            end
            mem_ack   = (k == ack_cyc);
            mem_rdata = rdata;
            #1;
            if (stall) g_stall_cnt++;
            else done = 1'b1;
        end
        if (!done) check_eq("mem_op.stall_bound", 32'h1, 32'h0);
        @(negedge clk);
        idle_inputs();
        check_eq("mem_op.req_after", 32'(mem_req), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        opcode = 7'h0; funct3 = 3'h0; rd = 5'h0; reg_write_data = 32'h0;
        data_addr = 32'h0; data_write = 32'h0; data_write_byte = 4'h0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst.mem_req", 32'(mem_req), 32'h0);
        check_eq("rst.mem_addr", mem_addr, 32'h0);
        check_eq("rst.mem_wstrb", 32'(mem_wstrb), 32'h0);
        check_wb("rst", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        alu_op(7'b0110011, 5'd3, 32'h0000_0005);
        check_wb("add", 1'b1, 1'b1, 5'd3, 32'h5, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("add.pulse", 32'(wb_valid), 32'h0);

        alu_op(7'b1100011, 5'd4, 32'h0000_0001);
        check_wb("branch", 1'b1, 1'b0, 5'd4, 32'h1, 1'b0, 1'b0);

        // Ack while idle must not produce writeback.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("idle_ack.wb_valid", 32'(wb_valid), 32'h0);

        mem_op(7'b0000011, 3'b000, 5'd5, 32'h0000_1003, 32'h0, 4'hf, 3, 32'h80FF_1234);
        check_eq("lb.stall_cnt", 32'(g_stall_cnt), 32'd3);
        check_eq("lb.mem_addr", g_addr, 32'h0000_1000);
        check_eq("lb.mem_wstrb", 32'(g_wstrb), 32'h0);
        check_eq("lb.mem_we", 32'(g_we), 32'h0);
        check_eq("lb.hold", 32'(g_hold_err), 32'h0);
        check_wb("lb", 1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 1'b0);

        mem_op(7'b0000011, 3'b100, 5'd5, 32'h0000_1003, 32'h0, 4'h0, 3, 32'h80FF_1234);
        check_wb("lbu", 1'b1, 1'b1, 5'd5, 32'h0000_0080, 1'b0, 1'b0);

        mem_op(7'b0000011, 3'b001, 5'd6, 32'h0000_1002, 32'h0, 4'h0, 1, 32'h80FF_1234);
        check_wb("lh", 1'b1, 1'b1, 5'd6, 32'hFFFF_80FF, 1'b0, 1'b0);

        mem_op(7'b0000011, 3'b101, 5'd6, 32'h0000_1000, 32'h0, 4'h0, 2, 32'h80FF_9234);
        check_wb("lhu", 1'b1, 1'b1, 5'd6, 32'h0000_9234, 1'b0, 1'b0);

        mem_op(7'b0000011, 3'b010, 5'd8, 32'h0000_1000, 32'h0, 4'h0, 1, 32'h80FF_1234);
        check_eq("lw.stall_cnt", 32'(g_stall_cnt), 32'd1);
        check_wb("lw", 1'b1, 1'b1, 5'd8, 32'h80FF_1234, 1'b0, 1'b0);

        mem_op(7'b0100011, 3'b001, 5'd0, 32'h0000_2002, 32'hBEEF_BEEF, 4'b1100, 1, 32'h0);
        check_eq("sh.mem_we", 32'(g_we), 32'h1);
        check_eq("sh.mem_wstrb", 32'(g_wstrb), 32'hc);
        check_eq("sh.mem_wdata", g_wdata, 32'hBEEF_BEEF);
        check_eq("sh.mem_addr", g_addr, 32'h0000_2000);
        check_wb("sh", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        mem_op(7'b0000011, 3'b010, 5'd9, 32'h0000_0006, 32'h0, 4'h0, 1, 32'h0);
        check_eq("mis.stall_cnt", 32'(g_stall_cnt), 32'd0);
        check_eq("mis.req_cnt", 32'(g_req_cnt), 32'd0);
        check_wb("mis", 1'b1, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0);

        mem_op(7'b0000011, 3'b010, 5'd10, 32'h0000_3000, 32'h0, 4'h0, 0, 32'h0);
        check_eq("tmo.req_cnt", 32'(g_req_cnt), 32'd4);
        check_eq("tmo.stall_cnt", 32'(g_stall_cnt), 32'd4);
        check_eq("tmo.hold", 32'(g_hold_err), 32'h0);
        check_wb("tmo", 1'b1, 1'b0, 5'd10, 32'h0, 1'b0, 1'b1);

        alu_op(7'b0010011, 5'd7, 32'h0000_1234);
        check_wb("addi", 1'b1, 1'b1, 5'd7, 32'h0000_1234, 1'b0, 1'b0);

        // Reset in the second ACCESS cycle abandons the load.
        @(negedge clk);
        ex_valid = 1'b1; opcode = 7'b0000011; funct3 = 3'b010; rd = 5'd11;
        data_addr = 32'h0000_4000;
        @(negedge clk);
        check_eq("rstacc.req1", 32'(mem_req), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rstacc.mem_req", 32'(mem_req), 32'h0);
        check_eq("rstacc.wb_valid", 32'(wb_valid), 32'h0);
        check_eq("rstacc.stall", 32'(stall), 32'h0);

        mem_op(7'b0000011, 3'b010, 5'd0, 32'h0000_4000, 32'h0, 4'h0, 1, 32'h1234_5678);
        check_wb("lw_x0", 1'b1, 1'b0, 5'd0, 32'h1234_5678, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute ALU.
- Consumes the ALU's address, store data, byte-enable and result outputs.
- Drives a single-outstanding req/ack data-memory bus, aligns and sign/zero-extends load data, and produces registered writeback.
- Stalls upstream while a memory access is in flight; aborts accesses on misalignment or bus timeout.

Parameters:
- MAX_WAIT, 255: cycles in ACCESS without mem_ack before abort; range 1..255, 8-bit counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ex_valid  in  1  upstream instruction valid
- opcode  in  7  RV32I opcode of the instruction
- funct3  in  3  RV32I funct3
- rd  in  5  destination register
- reg_write_data  in  32  ALU result for non-memory ops
- data_addr  in  32  effective address for load/store
- data_write  in  32  replicated store data
- data_write_byte  in  4  byte strobes, already shifted by data_addr[1:0]
- stall  out  1  upstream must hold all inputs (combinational)
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  {data_addr[31:2],2'b00}
- mem_wdata  out  32  store data
- mem_wstrb  out  4  store byte strobes; 0 for loads
- mem_ack  in  1  bus completion, single-cycle pulse
- mem_rdata  in  32  load word, valid with mem_ack
- wb_valid  out  1  writeback entry valid (1-cycle pulse)
- wb_we  out  1  register-file write enable
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- misaligned  out  1  1-cycle pulse alongside the aborting wb_valid
- bus_timeout  out  1  1-cycle pulse alongside the aborting wb_valid

Behaviour:
- Reset: synchronous; state=IDLE, wait counter=0.
- Reset forces all registered outputs to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_*, misaligned, bus_timeout.
- Reset mid-ACCESS abandons the access; mem_req is low the cycle after reset.
- States: IDLE, ACCESS.
- IDLE, ex_valid=0: wb_valid=0 next cycle.
- IDLE, ex_valid, non-memory opcode:
  - Next cycle: wb_valid=1, wb_data=reg_write_data, wb_rd=rd.
  - wb_we=1 for opcodes 0110011, 0010011, 1101111, 1100111, 0010111, 0110111; wb_we=0 for branch (1100011) and unknown opcodes.
  - Latency 1; no stall.
- IDLE, ex_valid, load (0000011) or store (0100011), aligned:
  - stall=1 this cycle.
  - Capture the mem_* fields and rd/funct3/addr[1:0]; go to ACCESS with mem_req=1 and counter=0.
- Misalignment:
  - Condition: half access (funct3[1:0]=01) with addr[0]=1, or word access (funct3[1:0]=10) with addr[1:0]!=0.
  - No bus request. Next cycle: wb_valid=1, wb_we=0, misaligned=1. No stall.
- ACCESS: mem_req and all mem_* outputs held stable until mem_ack.
- stall = (IDLE & ex_valid & aligned mem op) | (ACCESS & !mem_ack).
- ACCESS & mem_ack: mem_req=0 next cycle, state=IDLE, wb_valid=1 next cycle.
- Load writeback, with byte b=mem_rdata[8*addr[1:0]+:8] and half h=mem_rdata[16*addr[1]+:16]:
  - lb = sext(b); lbu = zext(b)
  - lh = sext(h); lhu = zext(h)
  - lw = mem_rdata
  - Unknown funct3: wb_we=0.
- Store writeback: wb_we=0, wb_data=0.
- wb_we is forced to 0 whenever wb_rd=0.
- Minimum load/store occupancy: 2 cycles (accept edge, ack in first ACCESS cycle). Loaded value appears in the cycle after ack.
- Timeout:
  - Counter increments each ACCESS cycle without ack.
  - When counter reaches MAX_WAIT-1 with no ack: drop mem_req, go to IDLE, then next cycle wb_valid=1, wb_we=0, bus_timeout=1; stall released the same cycle.
  - mem_ack arriving on the timeout cycle takes priority: normal completion.
- mem_ack while in IDLE is ignored.
- The upstream stage advances on the edge where stall=0. No second instruction is accepted during ACCESS.

Test Plan:
- add, reg_write_data=0x0000_0005, rd=3, ex_valid 1 cycle -> next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=5; stall never high.
- lb, data_addr=0x1003, mem_rdata=0x80FF_1234 with ack 3 cycles after accept -> mem_addr=0x1000, mem_wstrb=0, stall high 3 cycles; wb_data=0xFFFF_FF80; repeat with lbu -> 0x0000_0080.
- sh, data_addr=0x2002, data_write=0xBEEF_BEEF, data_write_byte=4'b1100, ack in first ACCESS cycle -> mem_we=1, mem_wstrb=4'b1100, mem_wdata held until ack; wb_valid=1, wb_we=0.
- lw, data_addr=0x0000_0006 -> no mem_req; next cycle wb_valid=1, wb_we=0, misaligned=1.
- lw aligned, mem_ack never asserted, MAX_WAIT=4 -> mem_req high exactly 4 cycles, then bus_timeout=1 with wb_valid=1, wb_we=0; a following addi completes normally.
- Load with reset=1 in the second ACCESS cycle -> next cycle mem_req=0, wb_valid=0, stall=0; a later lw with rd=0 completes with wb_we=0.
